axi_fifo: RTL and testbench

Synchronous valid/ready FIFO that buffers a stream of DW-bit beats between an upstream producer and the axi_rs register slice downstream of it. It absorbs bursts when the consumer stalls, so the slice sees a continuous stream. It also reports occupancy and an almost-full flag for upstream throttling. Storage is a register array with binary read/write pointers.

---
 rtl/axi_fifo.sv | 75 +++++++
 tb/tb_axi_fifo.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/axi_fifo.sv
// First-word-fall-through valid/ready FIFO with occupancy and almost-full.
// Register-array storage, binary pointers with an extra wrap bit.
module axi_fifo #(
  parameter int DW        = 64,
  parameter int DEPTH     = 16,
  parameter int AF_THRESH = DEPTH - 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] m_data,
  input  logic          m_valid,
  output logic          m_ready,
  output logic [DW-1:0] s_data,
  output logic          s_valid,
  input  logic          s_ready,
  output logic [$clog2(DEPTH):0] count,
  output logic          almost_full
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [AW:0] AF  = CW'(AF_THRESH);
  localparam logic [AW:0] ONE = CW'(1);

  logic [DW-1:0] mem [DEPTH];
  logic [AW:0]   wptr;
  logic [AW:0]   rptr;
  logic [AW:0]   count_nxt;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;

  assign empty = (wptr == rptr);
  assign full  = (wptr[AW-1:0] == rptr[AW-1:0]) &&
                 (wptr[AW] != rptr[AW]);

  assign m_ready = !full && !rst;
  assign s_valid = !empty;
  assign s_data  = mem[rptr[AW-1:0]];

  assign push = m_valid && m_ready;
  assign pop  = s_valid && s_ready;

  always_comb begin
    count_nxt = count;
    if (push && !pop)
      count_nxt = count + ONE;
    else if (pop && !push)
      count_nxt = count - ONE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr        <= '0;
      rptr        <= '0;
      count       <= '0;
      almost_full <= 1'b0;
    end else begin
      if (push)
        wptr <= wptr + ONE;
      if (pop)
        rptr <= rptr + ONE;
      count       <= count_nxt;
      almost_full <= (count_nxt >= AF);
    end
  end

  // Storage is not reset; push is already gated by !rst via m_ready.
  always_ff @(posedge clk) begin
    if (push)
      mem[wptr[AW-1:0]] <= m_data;
  end

endmodule

// File: tb/tb_axi_fifo.sv
// Scoreboard bench for axi_fifo: stimulus drives after each posedge,
// a negedge monitor tracks handshakes against a reference queue.
module tb_axi_fifo;

  localparam int DW = 64;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] m_data;
  logic          m_valid;
  logic          m_ready;
  logic [DW-1:0] s_data;
  logic          s_valid;
  logic          s_ready;
  logic [4:0]    count;
  logic          almost_full;

  int checks = 0;
  int failures = 0;

  logic [DW-1:0] exp_q[$];
  int mcnt = 0;

  axi_fifo #(
    .DW(DW),
    .DEPTH(DEPTH),
    .AF_THRESH(14)
  ) dut (
    .clk(clk),
    .rst(rst),
    .m_data(m_data),
    .m_valid(m_valid),
    .m_ready(m_ready),
    .s_data(s_data),
    .s_valid(s_valid),
    .s_ready(s_ready),
    .count(count),
    .almost_full(almost_full)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: state seen mid-cycle is the state the next edge acts on.
  always @(negedge clk) begin
    if (rst) begin
      chk("rst_m_ready", 64'(m_ready), 64'd0);
      chk("rst_s_valid", 64'(s_valid), 64'd0);
      chk("rst_count", 64'(count), 64'd0);
      chk("rst_af", 64'(almost_full), 64'd0);
      exp_q.delete();
      mcnt = 0;
    end else begin
      chk("mon_count", 64'(count), 64'(mcnt));
      chk("mon_m_ready", 64'(m_ready), 64'(mcnt < DEPTH));
      chk("mon_s_valid", 64'(s_valid), 64'(mcnt != 0));
      chk("mon_af", 64'(almost_full), 64'(mcnt >= 14));
      if (s_valid && s_ready) begin
        if (exp_q.size() == 0) begin
          chk("mon_underflow", 64'd1, 64'd0);
        end else begin
          chk("mon_data", s_data, exp_q.pop_front());
          mcnt--;
        end
      end
      if (m_valid && m_ready) begin
        exp_q.push_back(m_data);
        mcnt++;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    m_valid = 1'b0;
    s_ready = 1'b0;
    m_data = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    chk("ready_after_rst", 64'(m_ready), 64'd1);
    chk("count_after_rst", 64'(count), 64'd0);

    // Fill with 0x0..0xF while stalled.
    for (int i = 0; i < 16; i++) begin
      m_valid = 1'b1;
      m_data = 64'(i);
      tick();
      if (i == 12) chk("af_at_13", 64'(almost_full), 64'd0);
      if (i == 13) chk("af_at_14", 64'(almost_full), 64'd1);
    end
    chk("fill_count", 64'(count), 64'd16);
    chk("fill_m_ready", 64'(m_ready), 64'd0);
    m_data = 64'h77;
    tick();
    tick();
    chk("beat17_count", 64'(count), 64'd16);
    m_valid = 1'b0;

    // Drain in order.
    s_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      chk("drain_valid", 64'(s_valid), 64'd1);
      chk("drain_data", s_data, 64'(i));
      tick();
    end
    chk("drain_empty", 64'(s_valid), 64'd0);
    chk("drain_count", 64'(count), 64'd0);
    s_ready = 1'b0;

    // Full boundary: simultaneous push and pop admits only the pop.
    for (int i = 0; i < 16; i++) begin
      m_valid = 1'b1;
      m_data = 64'h100 + 64'(i);
      tick();
    end
    m_data = 64'h99;
    s_ready = 1'b1;
    tick();
    chk("fullpp_count", 64'(count), 64'd15);
    chk("fullpp_m_ready", 64'(m_ready), 64'd1);
    chk("fullpp_head", s_data, 64'h101);
    m_valid = 1'b0;
    repeat (15) tick();
    chk("fullpp_empty", 64'(s_valid), 64'd0);

    // Streaming with wrap: output is input one cycle later.
    m_valid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      m_data = 64'h1000 + 64'(i);
      tick();
      chk("stream_count", 64'(count), 64'd1);
      chk("stream_data", s_data, 64'h1000 + 64'(i));
    end
    m_valid = 1'b0;
    tick();
    chk("stream_end", 64'(s_valid), 64'd0);
    s_ready = 1'b0;

    // Random back-pressure.
    for (int i = 0; i < 10000; i++) begin
      m_valid = 1'($urandom_range(0, 1));
      s_ready = 1'($urandom_range(0, 1));
      m_data = {$urandom, $urandom};
      tick();
    end
    m_valid = 1'b0;
    s_ready = 1'b1;
    repeat (20) tick();
    chk("rand_drained", 64'(count), 64'd0);
    s_ready = 1'b0;

    // Reset mid-operation.
    for (int i = 0; i < 9; i++) begin
      m_valid = 1'b1;
      m_data = 64'h200 + 64'(i);
      tick();
    end
    m_valid = 1'b0;
    chk("pre_rst_count", 64'(count), 64'd9);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_count", 64'(count), 64'd0);
    chk("async_rst_valid", 64'(s_valid), 64'd0);
    chk("async_rst_ready", 64'(m_ready), 64'd0);
    tick();
    rst = 1'b0;
    m_valid = 1'b1;
    m_data = 64'hA5;
    tick();
    m_valid = 1'b0;
    chk("post_rst_valid", 64'(s_valid), 64'd1);
    chk("post_rst_data", s_data, 64'hA5);
    s_ready = 1'b1;
    tick();
    s_ready = 1'b0;
    chk("post_rst_empty", 64'(s_valid), 64'd0);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
